fft_frame_sequencer: RTL and testbench
======================================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, width of real and imaginary sample words.
REQ-002 Parameter TIMEOUT, default 1023, max cycles spent in WAIT for fft_valid_i.
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 frame_start_i  input  1  one-cycle pulse that opens a frame (UART rx header finished).
REQ-006 fft_select_i  input  2  frame size at frame_start_i: 0=8, 1=16, 2=32, 3=reserved.
REQ-007 rx_valid_i  input  1  one-cycle pulse, rx_R_i/rx_I_i hold a valid sample.
REQ-008 rx_R_i, rx_I_i  input  DATA_W each  incoming sample, real and imaginary.
REQ-009 abort_i  input  1  synchronous abort request.
REQ-010 wr_en_o  output  1  write strobe to the FFT input sample bank.
REQ-011 wr_addr_o  output  5  sample index being written.
REQ-012 wr_R_o, wr_I_o  output  DATA_W each  sample data for the write.
REQ-013 fft_start_o  output  1  one-cycle FFT start pulse.
REQ-014 fft_select_o  output  2  latched frame size, held stable for the whole frame.
REQ-015 fft_valid_i  input  1  FFT results valid.
REQ-016 rd_addr_o  output  5  result index driven to the FFT output mux.
REQ-017 rd_R_i, rd_I_i  input  DATA_W each  result at rd_addr_o, combinational from the mux.
REQ-018 tx_valid_o  output  1  result word offered to the UART transmitter.
REQ-019 tx_ready_i  input  1  UART transmitter accepts the word.
REQ-020 tx_R_o, tx_I_o  output  DATA_W each  result word, equal to rd_R_i/rd_I_i.
REQ-021 busy_o  output  1  high in any state other than IDLE.
REQ-022 done_o  output  1  one-cycle pulse after the last result is accepted.
REQ-023 err_o  output  1  one-cycle pulse on reserved select or on timeout.

Function
REQ-024 States: IDLE, LOAD, START, WAIT, SEND. N = 8, 16 or 32 from the latched select.
REQ-025 IDLE with frame_start_i and select != 3: latch select, clear cnt, go to LOAD next cycle.
REQ-026 IDLE with frame_start_i and select == 3: pulse err_o next cycle, stay in IDLE.
REQ-027 LOAD with rx_valid_i: on the next cycle wr_en_o=1, wr_addr_o=cnt and wr_R_o/wr_I_o=the registered sample; cnt increments.
REQ-028 LOAD accepts rx_valid_i on consecutive cycles with no gaps required.
REQ-029 LOAD: acceptance of sample N-1 moves the FSM to START.
REQ-030 START: fft_start_o=1 for exactly one cycle, then WAIT; the wait timer is cleared on entry to WAIT.
REQ-031 WAIT: fft_valid_i=1 moves to SEND with rd_addr_o=0.
REQ-032 WAIT: timer reaching TIMEOUT with no fft_valid_i pulses err_o and returns to IDLE.
REQ-033 SEND: tx_valid_o=1, and it is held with rd_addr_o stable until tx_valid_o and tx_ready_i are high in the same cycle.
REQ-034 SEND: each such transfer increments rd_addr_o.
REQ-035 SEND: the transfer at index N-1 pulses done_o and returns to IDLE; tx_valid_o is low the following cycle.
REQ-036 frame_start_i outside IDLE is ignored.
REQ-037 rx_valid_i outside LOAD is ignored.
REQ-038 fft_valid_i outside WAIT is ignored.
REQ-039 tx_ready_i with tx_valid_o=0 has no effect.
REQ-040 abort_i in any state: IDLE next cycle, all strobes low, no done_o, no err_o; abort_i takes priority over every simultaneous event.
REQ-041 cnt and rd_addr_o are 5-bit and never wrap past N-1; the terminal index always ends the phase.

Reset
REQ-042 rst low forces IDLE immediately; cnt=0, timer=0, all outputs 0, including fft_select_o and the data outputs.
REQ-043 rst low mid-frame discards the frame; after release the block waits for a new frame_start_i.

Verification
REQ-044 select=0, 8 back-to-back rx_valid_i with R=k, I=-k -> wr_addr_o 0..7 carrying matching data, one fft_start_o, fft_valid_i after 20 cycles, 8 tx words, one done_o.
REQ-045 select=2, tx_ready_i toggling 1/0 -> 32 transfers in index order, no index skipped or repeated, tx_valid_o never drops mid-word.
REQ-046 select=3 -> single err_o, busy_o stays 0, no wr_en_o.
REQ-047 select=1, fft_valid_i never asserted -> err_o exactly TIMEOUT cycles after entering WAIT, then IDLE.
REQ-048 abort_i at sample 5 of 16 -> IDLE next cycle, no fft_start_o; a new frame afterwards completes normally.
REQ-049 rst low during SEND at index 3 -> all outputs 0 asynchronously, busy_o=0 after release.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer around an FFT core: loads N samples from the UART receiver,
// starts the FFT, waits for results with a timeout and streams them to the transmitter.
module fft_frame_sequencer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start_i,
    input  logic [1:0]        fft_select_i,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_R_i,
    input  logic [DATA_W-1:0] rx_I_i,
    input  logic              abort_i,
    output logic              wr_en_o,
    output logic [4:0]        wr_addr_o,
    output logic [DATA_W-1:0] wr_R_o,
    output logic [DATA_W-1:0] wr_I_o,
    output logic              fft_start_o,
    output logic [1:0]        fft_select_o,
    input  logic              fft_valid_i,
    output logic [4:0]        rd_addr_o,
    input  logic [DATA_W-1:0] rd_R_i,
    input  logic [DATA_W-1:0] rd_I_i,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [DATA_W-1:0] tx_R_o,
    output logic [DATA_W-1:0] tx_I_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [4:0]          rd_addr_q, rd_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [4:0]          wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_r_q, wr_r_d;
    logic [DATA_W-1:0]   wr_i_q, wr_i_d;
    logic                fft_start_q, fft_start_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [4:0]          last_idx;

    // Terminal index of the latched frame size
    always_comb begin
        case (sel_q)
            2'd0:    last_idx = 5'd7;
            2'd1:    last_idx = 5'd15;
            default: last_idx = 5'd31;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            cnt_q       <= 5'd0;
            timer_q     <= '0;
            rd_addr_q   <= 5'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_r_q      <= '0;
            wr_i_q      <= '0;
            fft_start_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_r_q      <= wr_r_d;
            wr_i_q      <= wr_i_d;
            fft_start_q <= fft_start_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        rd_addr_d   = rd_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_r_d      = wr_r_q;
        wr_i_d      = wr_i_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start_i) begin
                    if (fft_select_i == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d   = fft_select_i;
                        cnt_d   = 5'd0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (rx_valid_i) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_r_d    = rx_R_i;
                    wr_i_d    = rx_I_i;
                    if (cnt_q == last_idx) begin
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fft_valid_i) begin
                    rd_addr_d = 5'd0;
                    state_d   = ST_SEND;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready_i) begin
                    if (rd_addr_q == last_idx) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything decided above
        if (abort_i) begin
            state_d = ST_IDLE;
            wr_en_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end

        fft_start_d = (state_d == ST_START);
        tx_valid_d  = (state_d == ST_SEND);
        busy_d      = (state_d != ST_IDLE);
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_R_o       = wr_r_q;
    assign wr_I_o       = wr_i_q;
    assign fft_start_o  = fft_start_q;
    assign fft_select_o = sel_q;
    assign rd_addr_o    = rd_addr_q;
    assign tx_valid_o   = tx_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

    // Result word passes straight from the mux, zeroed while no word is offered
    assign tx_R_o = tx_valid_q ? rd_R_i : '0;
    assign tx_I_o = tx_valid_q ? rd_I_i : '0;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: randomized frames, expected writes and
// transmit words queued by the stimulus and popped by an independent monitor.
module tb_fft_frame_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned TO = 40;

    typedef struct packed {
        logic [4:0]    idx;
        logic [DW-1:0] r;
        logic [DW-1:0] i;
    } item_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start_i, rx_valid_i, abort_i, fft_valid_i, tx_ready_i;
    logic [1:0]    fft_select_i;
    logic [DW-1:0] rx_R_i, rx_I_i, rd_R_i, rd_I_i;
    logic          wr_en_o, fft_start_o, tx_valid_o, busy_o, done_o, err_o;
    logic [4:0]    wr_addr_o, rd_addr_o;
    logic [DW-1:0] wr_R_o, wr_I_o, tx_R_o, tx_I_o;
    logic [1:0]    fft_select_o;

    logic [DW-1:0] res_r [32];
    logic [DW-1:0] res_i [32];

    item_t wr_q[$];
    item_t tx_q[$];

    int n_tests = 0, n_fail = 0;
    int n_start = 0, n_done = 0, n_err = 0;
    int cyc = 0, t_start = 0, t_err = 0;
    logic [1:0] exp_sel = 2'd0;
    logic       prev_hold = 1'b0;
    logic [4:0] prev_addr = 5'd0;

    fft_frame_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .frame_start_i(frame_start_i), .fft_select_i(fft_select_i),
        .rx_valid_i(rx_valid_i), .rx_R_i(rx_R_i), .rx_I_i(rx_I_i),
        .abort_i(abort_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_R_o(wr_R_o), .wr_I_o(wr_I_o),
        .fft_start_o(fft_start_o), .fft_select_o(fft_select_o),
        .fft_valid_i(fft_valid_i), .rd_addr_o(rd_addr_o),
        .rd_R_i(rd_R_i), .rd_I_i(rd_I_i),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .tx_R_o(tx_R_o), .tx_I_o(tx_I_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Result bank stand-in: combinational read at rd_addr_o
    assign rd_R_i = res_r[rd_addr_o];
    assign rd_I_i = res_i[rd_addr_o];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        item_t e;
        if (rst) begin
            if (wr_en_o) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 64'(wr_addr_o), 64'hFFFF);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_word", 64'({wr_addr_o, wr_R_o, wr_I_o}), 64'(e));
                end
            end
            if (tx_valid_o && tx_ready_i) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", 64'(rd_addr_o), 64'hFFFF);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_word", 64'({rd_addr_o, tx_R_o, tx_I_o}), 64'(e));
                end
            end
            if (prev_hold) check("tx_hold", 64'({tx_valid_o, rd_addr_o}), 64'({1'b1, prev_addr}));
            if (busy_o) check("sel_held", 64'(fft_select_o), 64'(exp_sel));
            prev_hold = tx_valid_o && !tx_ready_i;
            prev_addr = rd_addr_o;
            if (fft_start_o) begin n_start++; t_start = cyc; end
            if (done_o) n_done++;
            if (err_o) begin n_err++; t_err = cyc; end
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic clear_inputs();
        frame_start_i = 1'b0; fft_select_i = 2'd0; rx_valid_i = 1'b0;
        abort_i = 1'b0; fft_valid_i = 1'b0; tx_ready_i = 1'b0;
    endtask

    task automatic load_frame(input int sel, input bit b2b, input bit fixed, input int abort_at);
        int n;
        logic [DW-1:0] r, im;
        n = 8 << sel;
        exp_sel = 2'(sel);
        frame_start_i = 1'b1; fft_select_i = 2'(sel);
        tick();
        frame_start_i = 1'b0; fft_select_i = 2'($urandom);
        for (int k = 0; k < n; k++) begin
            if (!b2b) begin
                while ($urandom_range(0, 2) == 0) begin
                    rx_valid_i = 1'b0; fft_valid_i = 1'($urandom);
                    frame_start_i = 1'($urandom); tx_ready_i = 1'($urandom);
                    tick();
                end
            end
            r  = fixed ? DW'(k)  : DW'($urandom);
            im = fixed ? DW'(-k) : DW'($urandom);
            rx_valid_i = 1'b1; rx_R_i = r; rx_I_i = im;
            fft_valid_i = 1'b0; frame_start_i = 1'b0;
            if (k == abort_at) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0; rx_valid_i = 1'b0;
                return;
            end
            wr_q.push_back({5'(k), r, im});
            tick();
        end
        clear_inputs();
    endtask

    task automatic wait_start(input int s0);
        int guard = 0;
        while (n_start == s0 && guard < 8) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("start_pulse", 64'(n_start - s0), 64'd1);
    endtask

    // mode: 0 ready always, 1 ready toggling, 2 ready random; delay < 0 never sends fft_valid
    task automatic run_frame(input int sel, input bit b2b, input int mode, input int delay, input bit fixed);
        int s0, d0, e0, n, guard;
        bit phase;
        s0 = n_start; d0 = n_done; e0 = n_err; n = 8 << sel;
        for (int k = 0; k < 32; k++) begin
            res_r[k] = DW'($urandom);
            res_i[k] = DW'($urandom);
        end
        load_frame(sel, b2b, fixed, -1);
        wait_start(s0);
        if (delay < 0) begin
            guard = 0;
            while (n_err == e0 && guard < int'(TO) + 20) begin
                rx_valid_i = 1'($urandom); tx_ready_i = 1'($urandom);
                tick();
                guard++;
            end
            clear_inputs();
            check("timeout_err", 64'(n_err - e0), 64'd1);
            check("timeout_cycles", 64'(t_err - t_start), 64'(TO + 1));
            check("timeout_idle", 64'(busy_o), 64'd0);
            check("timeout_no_done", 64'(n_done - d0), 64'd0);
        end else begin
            for (int d = 0; d < delay; d++) begin
                rx_valid_i = 1'($urandom); tx_ready_i = 1'($urandom);
                tick();
            end
            for (int k = 0; k < n; k++) tx_q.push_back({5'(k), res_r[k], res_i[k]});
            rx_valid_i = 1'b0; tx_ready_i = 1'b0; fft_valid_i = 1'b1;
            tick();
            fft_valid_i = 1'b0;
            phase = 1'b1; guard = 0;
            while (n_done == d0 && guard < 600) begin
                tx_ready_i  = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom);
                phase       = ~phase;
                rx_valid_i  = 1'($urandom);
                fft_valid_i = 1'($urandom);
                tick();
                guard++;
            end
            clear_inputs();
            check("done_pulse", 64'(n_done - d0), 64'd1);
            check("tx_all_sent", 64'(tx_q.size()), 64'd0);
            check("tx_low_after_done", 64'({tx_valid_o, busy_o}), 64'd0);
            check("no_err", 64'(n_err - e0), 64'd0);
        end
        check("wr_all_seen", 64'(wr_q.size()), 64'd0);
        check("single_start", 64'(n_start - s0), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0, guard;
        logic bsy;
        rst = 1'b0;
        clear_inputs();
        rx_R_i = '0; rx_I_i = '0;
        for (int k = 0; k < 32; k++) begin
            res_r[k] = DW'($urandom) | DW'(1);
            res_i[k] = DW'($urandom) | DW'(1);
        end
        #3;
        check("reset_ctrl", 64'({wr_en_o, wr_addr_o, fft_start_o, fft_select_o, rd_addr_o,
                                  tx_valid_o, busy_o, done_o, err_o}), 64'd0);
        check("reset_data", 64'({wr_R_o, wr_I_o, tx_R_o, tx_I_o}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();

        // 8-point frame, back-to-back samples k / -k, results after 20 cycles
        run_frame(0, 1'b1, 0, 20, 1'b1);

        // 32-point frame with tx_ready toggling
        run_frame(2, 1'b1, 1, 5, 1'b0);

        // Reserved select
        e0 = n_err;
        frame_start_i = 1'b1; fft_select_i = 2'd3;
        tick();
        clear_inputs();
        check("rsv_err_now", 64'({err_o, busy_o}), 64'b10);
        bsy = 1'b0;
        repeat (4) begin tick(); bsy |= busy_o; end
        check("rsv_busy", 64'(bsy), 64'd0);
        check("rsv_err_count", 64'(n_err - e0), 64'd1);

        // Timeout on a 16-point frame
        run_frame(1, 1'b0, 2, -1, 1'b0);

        // Abort at sample 5 of 16, then a clean frame
        s0 = n_start;
        load_frame(1, 1'b1, 1'b0, 5);
        check("abort_idle", 64'({busy_o, wr_en_o}), 64'd0);
        repeat (5) tick();
        check("abort_no_start", 64'(n_start - s0), 64'd0);
        check("abort_wr_flushed", 64'(wr_q.size()), 64'd0);
        run_frame(1, 1'b0, 2, 7, 1'b0);

        // Reset while sending index 3
        for (int k = 0; k < 32; k++) begin
            res_r[k] = DW'($urandom) | DW'(1);
            res_i[k] = DW'($urandom) | DW'(1);
        end
        s0 = n_start;
        load_frame(2, 1'b1, 1'b0, -1);
        wait_start(s0);
        repeat (3) tick();
        for (int k = 0; k < 32; k++) tx_q.push_back({5'(k), res_r[k], res_i[k]});
        fft_valid_i = 1'b1;
        tick();
        fft_valid_i = 1'b0; tx_ready_i = 1'b1;
        guard = 0;
        while (rd_addr_o != 5'd3 && guard < 50) begin tick(); guard++; end
        check("send_reached_3", 64'({tx_valid_o, rd_addr_o}), 64'({1'b1, 5'd3}));
        #1 rst = 1'b0;
        #1;
        check("async_rst_ctrl", 64'({wr_en_o, wr_addr_o, fft_start_o, fft_select_o, rd_addr_o,
                                      tx_valid_o, busy_o, done_o, err_o}), 64'd0);
        check("async_rst_data", 64'({wr_R_o, wr_I_o, tx_R_o, tx_I_o}), 64'd0);
        tx_q.delete();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        bsy = 1'b0;
        repeat (5) begin tick(); bsy |= busy_o; end
        check("post_rst_idle", 64'(bsy), 64'd0);

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(0, 2), 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, TO - 2), 1'b0);
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
